// File: rtl/drum_voice_mixer_pkg.sv
// Shared types and helpers for the polyphonic drum voice mixer.
package drum_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUTPUT} mix_state_t;

  // Accumulator width: sample width, plus headroom for the voice sum, plus sign margin.
  function automatic int acc_width(input int n, input int dw);
    return dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/drum_voice_ctr.sv
// Per-voice playback position, active flag and collapsed pending-trigger bit.
module drum_voice_ctr #(
  parameter int          AW        = 12,
  parameter logic [AW-1:0] LEN     = 12'd900,
  parameter bit          RETRIGGER = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          apply_i,
  input  logic          advance_i,
  input  logic          trigger_i,
  output logic [AW-1:0] pos_nxt_o,
  output logic          play_o
);

  logic          pend_q, pend_d, pend_now;
  logic          play_q, play_d;
  logic [AW-1:0] pos_q, pos_d;

  assign pend_now = pend_q | trigger_i;

  always_comb begin
    pos_d  = pos_q;
    play_d = play_q;
    pend_d = pend_now;
    if (apply_i) begin
      pend_d = 1'b0;
      if (pend_now) begin
        if (!play_q) begin
          pos_d  = '0;
          play_d = 1'b1;
        end else if (RETRIGGER) begin
          pos_d = '0;
        end
      end
    end else if (advance_i && play_q) begin
      if (pos_q == LEN - 1'b1) begin
        pos_d  = '0;
        play_d = 1'b0;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      play_q <= 1'b0;
      pos_q  <= '0;
    end else begin
      pend_q <= pend_d;
      play_q <= play_d;
      pos_q  <= pos_d;
    end
  end

  // The address for a voice is latched on the edge that applies its trigger.
  assign pos_nxt_o = pos_d;
  assign play_o    = play_q;

endmodule

// File: rtl/drum_voice_mixer.sv
// Time-multiplexed N-voice one-shot sample player summing into one saturated sample.
module drum_voice_mixer
  import drum_pkg::*;
#(
  parameter int                    N_VOICES   = 4,
  parameter int                    AW         = 12,
  parameter int                    DW         = 8,
  parameter logic [N_VOICES*AW-1:0] VOICE_BASE = {12'd2700, 12'd1800, 12'd900, 12'd0},
  parameter logic [N_VOICES*AW-1:0] VOICE_LEN  = {4{12'd900}},
  parameter bit                    RETRIGGER  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic [N_VOICES-1:0]  trigger,
  output logic [AW-1:0]        rom_addr,
  input  logic signed [DW-1:0] rom_data,
  output logic signed [DW-1:0] mix_out,
  output logic                 mix_valid,
  output logic [N_VOICES-1:0]  playing,
  output logic                 overrun
);

  localparam int ACC_W = acc_width(N_VOICES, DW);
  localparam int IW    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_VOICES - 1);

  function automatic logic signed [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi, lo;
    hi = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < lo) return {1'b1, {(DW-1){1'b0}}};
    else             return v[DW-1:0];
  endfunction

  mix_state_t              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d, sel;
  logic                    accept, load;
  logic [AW-1:0]           rom_addr_q, rom_addr_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [DW-1:0]    mix_q, mix_d;
  logic                    add_en_q;
  logic [AW-1:0]           base    [N_VOICES];
  logic [AW-1:0]           pos_nxt [N_VOICES];
  logic [N_VOICES-1:0]     play;

  assign accept    = (state_q == IDLE) && sample_tick;
  assign overrun   = sample_tick && (state_q != IDLE);
  assign mix_valid = (state_q == OUTPUT);

  for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
    assign base[i] = VOICE_BASE[i*AW +: AW];
    drum_voice_ctr #(
      .AW(AW), .LEN(VOICE_LEN[i*AW +: AW]), .RETRIGGER(RETRIGGER)
    ) u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .apply_i   (accept),
      .advance_i ((state_q == FETCH) && (idx_q == IW'(i))),
      .trigger_i (trigger[i]),
      .pos_nxt_o (pos_nxt[i]),
      .play_o    (play[i])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:   if (sample_tick) begin state_d = FETCH; idx_d = '0; end
      FETCH:  if (idx_q == LAST) state_d = DRAIN; else idx_d = idx_q + 1'b1;
      DRAIN:  state_d = OUTPUT;
      OUTPUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address for the next voice is registered one cycle ahead of its FETCH slot.
  always_comb begin
    sel        = accept ? '0 : idx_q + 1'b1;
    load       = accept || ((state_q == FETCH) && (idx_q != LAST));
    rom_addr_d = rom_addr_q;
    if (load) rom_addr_d = base[sel] + pos_nxt[sel];
  end

  always_comb begin
    acc_sum = acc_q + (add_en_q ? $signed({{(ACC_W-DW){rom_data[DW-1]}}, rom_data})
                                : {ACC_W{1'b0}});
    acc_d   = accept ? '0 : acc_sum;
    mix_d   = (state_q == DRAIN) ? sat(acc_sum) : mix_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      acc_q      <= '0;
      mix_q      <= '0;
      add_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      acc_q      <= acc_d;
      mix_q      <= mix_d;
      add_en_q   <= (state_q == FETCH) && play[idx_q];
    end
  end

  assign rom_addr = rom_addr_q;
  assign mix_out  = mix_q;
  assign playing  = play;

endmodule

// File: tb/tb_drum_voice_mixer.sv
// Directed bench: one retriggering and one non-retriggering mixer share stimulus.
module tb_drum_voice_mixer;

  localparam int N = 4, AW = 12, DW = 8;
  localparam logic [N*AW-1:0] BASE = {12'd2700, 12'd1800, 12'd900, 12'd0};
  localparam logic [N*AW-1:0] LENS = {12'd900, 12'd900, 12'd900, 12'd4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, sample_tick;
  logic [N-1:0]         trigger;
  logic [AW-1:0]        rom_addr, rom_addr_nr;
  logic signed [DW-1:0] rom_data, rom_data_nr, mix_out, mix_out_nr;
  logic                 mix_valid, mix_valid_nr, overrun, overrun_nr;
  logic [N-1:0]         playing, playing_nr;
  int                   rom_mode;

  int checks = 0, failures = 0;
  int s_mix, s_mix_nr, s_a0, s_a0nr, s_lat, s_nvalid, s_ovr;

  drum_voice_mixer #(.N_VOICES(N), .AW(AW), .DW(DW), .VOICE_BASE(BASE),
                     .VOICE_LEN(LENS), .RETRIGGER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .trigger(trigger),
    .rom_addr(rom_addr), .rom_data(rom_data), .mix_out(mix_out),
    .mix_valid(mix_valid), .playing(playing), .overrun(overrun));

  drum_voice_mixer #(.N_VOICES(N), .AW(AW), .DW(DW), .VOICE_BASE(BASE),
                     .VOICE_LEN(LENS), .RETRIGGER(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .trigger(trigger),
    .rom_addr(rom_addr_nr), .rom_data(rom_data_nr), .mix_out(mix_out_nr),
    .mix_valid(mix_valid_nr), .playing(playing_nr), .overrun(overrun_nr));

  function automatic logic signed [DW-1:0] rom_f(input logic [AW-1:0] a, input int mode);
    case (mode)
      1:       return 8'sd100;
      2:       return -8'sd100;
      3:       return 8'sd20;
      default: return $signed({2'b00, a[5:0]} + 8'd1);
    endcase
  endfunction

  always @(posedge clk) begin
    rom_data    <= rom_f(rom_addr, rom_mode);
    rom_data_nr <= rom_f(rom_addr_nr, rom_mode);
  end

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    int nv;
    nv    = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_tick = i[0];
      trigger     = i[0] ? 4'hF : 4'h5;
      @(negedge clk);
      if (mix_valid) nv++;
    end
    check_val("rst_mix_valid_cnt", nv, 0);
    check_val("rst_rom_addr", int'(rom_addr), 0);
    check_val("rst_mix_out", int'(mix_out), 0);
    check_val("rst_playing", int'(playing), 0);
    rst_n       = 1'b1;
    sample_tick = 1'b0;
    trigger     = '0;
  endtask

  // One 20-cycle tick period; cycle 0 is the tick cycle.
  task automatic scan(input logic [N-1:0] trig, input bit extra, input int rst_at);
    @(negedge clk);
    sample_tick = 1'b1;
    trigger     = trig;
    @(negedge clk);
    sample_tick = 1'b0;
    trigger     = '0;
    s_a0 = int'(rom_addr); s_a0nr = int'(rom_addr_nr);
    s_lat = -1; s_nvalid = 0; s_ovr = 0; s_mix = -999; s_mix_nr = -999;
    for (int c = 1; c <= 19; c++) begin
      if (mix_valid) begin
        s_nvalid++;
        if (s_lat < 0) s_lat = c;
        s_mix    = int'(mix_out);
        s_mix_nr = int'(mix_out_nr);
      end
      if (extra && c == 3) begin
        sample_tick = 1'b1;
        #1;
        s_ovr = int'(overrun);
      end
      if (extra && c == 4) sample_tick = 1'b0;
      if (c == rst_at) rst_n = 1'b0;
      if (rst_at > 0 && c == rst_at + 2) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sample_tick = 1'b0; trigger = '0; rom_mode = 0;
    do_reset();

    // One-shot voice 0, length 4, ROM data = addr[5:0]+1
    scan(4'h1, 1'b0, -1);
    check_val("os_addr0", s_a0, 0);
    check_val("os_mix0", s_mix, 1);
    check_val("os_latency", s_lat, 6);
    scan(4'h0, 1'b0, -1);
    check_val("os_addr1", s_a0, 1);
    check_val("os_mix1", s_mix, 2);
    scan(4'h0, 1'b0, -1);
    check_val("os_addr2", s_a0, 2);
    check_val("os_mix2", s_mix, 3);
    check_val("os_play_after3", int'(playing[0]), 1);
    scan(4'h0, 1'b0, -1);
    check_val("os_addr3", s_a0, 3);
    check_val("os_mix3", s_mix, 4);
    check_val("os_play_after4", int'(playing[0]), 0);
    scan(4'h0, 1'b0, -1);
    check_val("os_mix_silent", s_mix, 0);
    check_val("os_silent_valid", s_nvalid, 1);

    // Retrigger after two samples
    do_reset();
    scan(4'h1, 1'b0, -1);
    check_val("rt_mix0", s_mix, 1);
    scan(4'h0, 1'b0, -1);
    scan(4'h1, 1'b0, -1);
    check_val("rt_addr_retrig", s_a0, 0);
    check_val("rt_mix_retrig", s_mix, 1);
    check_val("rt_addr_noretrig", s_a0nr, 2);
    check_val("rt_mix_noretrig", s_mix_nr, 3);

    // Saturation with all four voices playing
    do_reset();
    rom_mode = 1;
    scan(4'hF, 1'b0, -1);
    check_val("sat_pos", s_mix, 127);
    check_val("sat_playing", int'(playing), 15);
    rom_mode = 2;
    scan(4'h0, 1'b0, -1);
    check_val("sat_neg", s_mix, -128);
    rom_mode = 3;
    scan(4'h0, 1'b0, -1);
    check_val("sat_inrange", s_mix, 80);

    // Dropped tick during a scan; voices at position 3 give 4+8+12+16
    rom_mode = 0;
    scan(4'h0, 1'b1, -1);
    check_val("ovr_latency", s_lat, 6);
    check_val("ovr_flag", s_ovr, 1);
    check_val("ovr_valid_cnt", s_nvalid, 1);
    check_val("ovr_mix", s_mix, 40);

    // Reset in the middle of a scan
    scan(4'h1, 1'b0, 3);
    check_val("mrst_valid_cnt", s_nvalid, 0);
    check_val("mrst_playing", int'(playing), 0);
    scan(4'h0, 1'b0, -1);
    check_val("mrst_next_mix", s_mix, 0);
    check_val("mrst_next_valid", s_nvalid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
